// File: rtl/bcd_press_counter.sv
// bcd_press_counter: counts debounced up/down presses as a 4-digit BCD value
// (0000..9999, wrapping) and scans it onto a common-anode 7-segment display.
module bcd_press_counter #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk_1M,
  input  logic        rst,
  input  logic        up_db,
  input  logic        down_db,
  input  logic        clr,
  output logic [15:0] count_bcd,
  output logic        change,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SCAN_W = 16;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned NIB_W  = 4;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic                r_up_prev;
  logic                r_down_prev;
  logic [CNT_W-1:0]    r_count;
  logic                r_change;
  logic [SCAN_W-1:0]   r_scan;
  logic [IDX_W-1:0]    r_digit;

  logic                w_up_ev;
  logic                w_down_ev;
  logic [CNT_W-1:0]    w_inc;
  logic [CNT_W-1:0]    w_dec;
  logic [NIB_W-1:0]    w_nib;
  logic                w_blank;

  assign w_up_ev   = up_db & ~r_up_prev;
  assign w_down_ev = down_db & ~r_down_prev;

  assign count_bcd = r_count;
  assign change    = r_change;

  // BCD +1 and -1 of the current count, rippling carry/borrow across digits
  always_comb begin : bcd_step
    logic v_carry;
    logic v_borrow;
    w_inc    = r_count;
    w_dec    = r_count;
    v_carry  = 1'b1;
    v_borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v_carry) begin
        if (r_count[i*4 +: 4] == 4'd9) begin
          w_inc[i*4 +: 4] = 4'd0;
        end else begin
          w_inc[i*4 +: 4] = r_count[i*4 +: 4] + 4'd1;
          v_carry         = 1'b0;
        end
      end
      if (v_borrow) begin
        if (r_count[i*4 +: 4] == 4'd0) begin
          w_dec[i*4 +: 4] = 4'd9;
        end else begin
          w_dec[i*4 +: 4] = r_count[i*4 +: 4] - 4'd1;
          v_borrow        = 1'b0;
        end
      end
    end
  end

  // Edge history and count update: clear beats events, simultaneous events cancel
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      r_up_prev   <= 1'b0;
      r_down_prev <= 1'b0;
      r_count     <= '0;
      r_change    <= 1'b0;
    end else begin
      r_up_prev   <= up_db;
      r_down_prev <= down_db;
      r_change    <= 1'b0;
      if (clr) begin
        r_count  <= '0;
        r_change <= 1'b1;
      end else if (w_up_ev && !w_down_ev) begin
        r_count  <= w_inc;
        r_change <= 1'b1;
      end else if (w_down_ev && !w_up_ev) begin
        r_count  <= w_dec;
        r_change <= 1'b1;
      end
    end
  end

  // Scan timer: each digit is held for SCAN_DIV cycles, then the index advances
  always_ff @(posedge clk_1M or posedge rst) begin
    if (rst) begin
      r_scan  <= '0;
      r_digit <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan  <= '0;
      r_digit <= r_digit + IDX_W'(1);
    end else begin
      r_scan  <= r_scan + SCAN_W'(1);
    end
  end

  // Select the scanned nibble and decide whether it is a leading zero
  always_comb begin
    w_nib   = r_count[3:0];
    w_blank = 1'b0;
    case (r_digit)
      2'd0: begin
        w_nib   = r_count[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_nib   = r_count[7:4];
        w_blank = (r_count[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib   = r_count[11:8];
        w_blank = (r_count[15:8] == 8'h00);
      end
      default: begin
        w_nib   = r_count[15:12];
        w_blank = (r_count[15:12] == 4'h0);
      end
    endcase
  end

  assign an = ~(4'b0001 << r_digit);

  // Active-low segment decode {g,f,e,d,c,b,a}; blanked digits are all off
  always_comb begin
    seg = 7'b1111111;
    if (!(BLANK_LZ && w_blank)) begin
      case (w_nib)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_press_counter.sv
// Self-checking bench for bcd_press_counter using a decimal reference model.
module tb_bcd_press_counter;

  localparam int unsigned SD = 4;

  logic        clk_1M  = 1'b0;
  logic        rst     = 1'b1;
  logic        up_db   = 1'b0;
  logic        down_db = 1'b0;
  logic        clr     = 1'b0;
  logic [15:0] count_bcd, count_nb;
  logic        change, change_nb;
  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;

  bcd_press_counter #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clk_1M(clk_1M), .rst(rst), .up_db(up_db), .down_db(down_db), .clr(clr),
    .count_bcd(count_bcd), .change(change), .an(an), .seg(seg)
  );

  bcd_press_counter #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
    .clk_1M(clk_1M), .rst(rst), .up_db(up_db), .down_db(down_db), .clr(clr),
    .count_bcd(count_nb), .change(change_nb), .an(an_nb), .seg(seg_nb)
  );

  always #5 clk_1M = ~clk_1M;

  // Reference model: decimal count, expected strobe, input history, cycles since reset
  int m_count = 0;
  bit m_change = 1'b0;
  bit m_up_prev = 1'b0;
  bit m_down_prev = 1'b0;
  int ncyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] glyph [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  function automatic logic [15:0] to_bcd(input int c);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int c, input int k, input bit blank);
    if (blank && k > 0 && c < pow10(k)) return 7'b1111111;
    return glyph[(c / pow10(k)) % 10];
  endfunction

  function automatic logic [3:0] exp_an(input int n);
    logic [3:0] a;
    a = 4'b1111;
    a[(n / SD) % 4] = 1'b0;
    return a;
  endfunction

  // Advance one clock and apply the behavioural rules to the model
  task automatic cyc();
    bit ue, de, cl;
    ue = up_db && !m_up_prev;
    de = down_db && !m_down_prev;
    cl = clr;
    m_up_prev   = up_db;
    m_down_prev = down_db;
    @(posedge clk_1M);
    #1;
    ncyc++;
    if (cl) begin
      m_count = 0; m_change = 1'b1;
    end else if (ue && de) begin
      m_change = 1'b0;
    end else if (ue) begin
      m_count = (m_count + 1) % 10000; m_change = 1'b1;
    end else if (de) begin
      m_count = (m_count + 9999) % 10000; m_change = 1'b1;
    end else begin
      m_change = 1'b0;
    end
  endtask

  task automatic pulse_up();
    up_db = 1'b1; cyc(); up_db = 1'b0; cyc();
  endtask

  task automatic pulse_down();
    down_db = 1'b1; cyc(); down_db = 1'b0; cyc();
  endtask

  task automatic goto_count(input int target);
    int d;
    d = (target - m_count + 10000) % 10000;
    if (d <= 5000) for (int i = 0; i < d; i++) pulse_up();
    else for (int i = 0; i < 10000 - d; i++) pulse_down();
  endtask

  task automatic model_reset();
    m_count = 0; m_change = 1'b0; m_up_prev = 1'b0; m_down_prev = 1'b0; ncyc = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_1M);
    #1;
    n_checks++;
    if (count_bcd !== 16'h0000 || change !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_count: count=%h change=%b, required 0000/0", count_bcd, change);
    end
    n_checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      n_errors++;
      $display("FAIL reset_display: an=%b seg=%b, required 1110/1000000", an, seg);
    end
    rst = 1'b0;
    model_reset();
    repeat (SD) cyc();
    n_checks++;
    if (an !== 4'b1101 || seg !== 7'b1111111) begin
      n_errors++;
      $display("FAIL reset_scan1: an=%b seg=%b, required 1101/1111111", an, seg);
    end
  endtask

  task automatic test_pulses();
    int nchg = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) begin
        up_db = (i < 5);
        cyc();
        if (change === 1'b1) nchg++;
        n_checks++;
        if (change !== m_change || count_bcd !== to_bcd(m_count)) begin
          n_errors++;
          $display("FAIL pulse_cycle p%0d i%0d: count=%h change=%b, required %h/%b",
                   p, i, count_bcd, change, to_bcd(m_count), m_change);
        end
        if (i == 0) begin
          n_checks++;
          if (change !== 1'b1) begin
            n_errors++;
            $display("FAIL pulse_strobe p%0d: change=%b, required 1", p, change);
          end
        end
      end
    end
    up_db = 1'b0;
    n_checks++;
    if (count_bcd !== 16'h0003 || nchg != 3) begin
      n_errors++;
      $display("FAIL pulse_total: count=%h strobes=%0d, required 0003/3", count_bcd, nchg);
    end
  endtask

  task automatic test_wrap();
    goto_count(99);
    n_checks++;
    if (count_bcd !== 16'h0099) begin
      n_errors++; $display("FAIL preload_99: count=%h, required 0099", count_bcd);
    end
    pulse_up();
    n_checks++;
    if (count_bcd !== 16'h0100) begin
      n_errors++; $display("FAIL inc_0100: count=%h, required 0100", count_bcd);
    end
    goto_count(9999);
    n_checks++;
    if (count_bcd !== 16'h9999) begin
      n_errors++; $display("FAIL preload_9999: count=%h, required 9999", count_bcd);
    end
    pulse_up();
    n_checks++;
    if (count_bcd !== 16'h0000) begin
      n_errors++; $display("FAIL inc_wrap: count=%h, required 0000", count_bcd);
    end
    pulse_down();
    n_checks++;
    if (count_bcd !== 16'h9999) begin
      n_errors++; $display("FAIL dec_wrap: count=%h, required 9999", count_bcd);
    end
    pulse_down();
    n_checks++;
    if (count_bcd !== 16'h9998) begin
      n_errors++; $display("FAIL dec_9998: count=%h, required 9998", count_bcd);
    end
  endtask

  task automatic test_cancel_clear();
    goto_count(42);
    up_db = 1'b1; down_db = 1'b1;
    cyc();
    n_checks++;
    if (count_bcd !== 16'h0042 || change !== 1'b0) begin
      n_errors++;
      $display("FAIL cancel: count=%h change=%b, required 0042/0", count_bcd, change);
    end
    up_db = 1'b0; down_db = 1'b0;
    cyc();
    up_db = 1'b1; clr = 1'b1;
    cyc();
    n_checks++;
    if (count_bcd !== 16'h0000 || change !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_over_up: count=%h change=%b, required 0000/1", count_bcd, change);
    end
    up_db = 1'b0; clr = 1'b0;
    cyc();
    n_checks++;
    if (change !== 1'b0 || count_bcd !== 16'h0000) begin
      n_errors++;
      $display("FAIL clr_release: count=%h change=%b, required 0000/0", count_bcd, change);
    end
    pulse_up(); pulse_up();
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_db = (i == 1);
      cyc();
      n_checks++;
      if (count_bcd !== 16'h0000 || change !== 1'b1) begin
        n_errors++;
        $display("FAIL clr_hold i%0d: count=%h change=%b, required 0000/1", i, count_bcd, change);
      end
    end
    clr = 1'b0; up_db = 1'b0;
    cyc();
  endtask

  task automatic test_display();
    logic [6:0] seg_tab [0:3] = '{7'b0010010, 7'b1000000, 7'b1111000, 7'b1111111};
    logic [3:0] an_tab  [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int k;
    goto_count(705);
    for (int i = 0; i < 4 * SD + 2; i++) begin
      cyc();
      k = (ncyc / SD) % 4;
      n_checks++;
      if (an !== an_tab[k] || seg !== seg_tab[k]) begin
        n_errors++;
        $display("FAIL disp_0705 d%0d: an=%b seg=%b, required %b/%b", k, an, seg, an_tab[k], seg_tab[k]);
      end
      n_checks++;
      if (seg_nb !== exp_seg(m_count, k, 1'b0) || an_nb !== an_tab[k]) begin
        n_errors++;
        $display("FAIL disp_noblank d%0d: an=%b seg=%b, required %b/%b",
                 k, an_nb, seg_nb, an_tab[k], exp_seg(m_count, k, 1'b0));
      end
      if (k == 3) begin
        n_checks++;
        if (seg_nb !== 7'b1000000) begin
          n_errors++;
          $display("FAIL noblank_d3: seg=%b, required 1000000", seg_nb);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    goto_count(122);
    up_db = 1'b1;
    cyc();
    n_checks++;
    if (count_bcd !== 16'h0123) begin
      n_errors++; $display("FAIL pre_rst: count=%h, required 0123", count_bcd);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (count_bcd !== 16'h0000 || an !== 4'b1110) begin
      n_errors++; $display("FAIL rst_async: count=%h an=%b, required 0000/1110", count_bcd, an);
    end
    repeat (2) @(posedge clk_1M);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if (count_bcd !== 16'h0001 || change !== (i == 0)) begin
        n_errors++;
        $display("FAIL rst_release i%0d: count=%h change=%b, required 0001/%b",
                 i, count_bcd, change, (i == 0));
      end
    end
    up_db = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 600; i++) begin
      up_db   = ($urandom_range(0, 2) == 0);
      down_db = ($urandom_range(0, 2) == 0);
      clr     = ($urandom_range(0, 24) == 0);
      cyc();
      k = (ncyc / SD) % 4;
      n_checks++;
      if (count_bcd !== to_bcd(m_count) || change !== m_change) begin
        n_errors++;
        $display("FAIL rand_count i%0d: count=%h change=%b, required %h/%b",
                 i, count_bcd, change, to_bcd(m_count), m_change);
      end
      n_checks++;
      if (an !== exp_an(ncyc) || seg !== exp_seg(m_count, k, 1'b1)) begin
        n_errors++;
        $display("FAIL rand_disp i%0d: an=%b seg=%b, required %b/%b",
                 i, an, seg, exp_an(ncyc), exp_seg(m_count, k, 1'b1));
      end
    end
    up_db = 1'b0; down_db = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pulses();
    test_wrap();
    test_cancel_clear();
    test_display();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
